// File: rtl/coinc_pkg.sv
// coinc_pkg: shared helpers for the coincidence matcher.
// Index-width function and counter saturation constant.
package coinc_pkg;

    // Bit width needed to index w items; never below 1.
    function automatic int clog2w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // All-ones value of a w-bit counter (w <= 63).
    function automatic logic [63:0] cnt_sat(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/coinc_stretch.sv
// coinc_stretch: one-bit hit stretcher.
// A hit reloads a down-counter; win is high while it is non-zero.
module coinc_stretch
    import coinc_pkg::*;
#(
    parameter int WINDOW = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic hit,
    output logic win
);

    localparam int HW = clog2w(WINDOW + 1);
    localparam logic [HW-1:0] LOAD = HW'(WINDOW);

    logic [HW-1:0] hold;

    // Reload on hit, otherwise count down to zero; disable clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (!enable) begin
            hold <= '0;
        end else if (hit) begin
            hold <= LOAD;
        end else if (hold != '0) begin
            hold <= hold - HW'(1);
        end
    end

    assign win = (hold != '0);

endmodule

// File: rtl/coinc_match.sv
// coinc_match: A/B same-index coincidence matcher with window.
// Optional channel mask when COINC_MASK_EN is defined.
module coinc_match
    import coinc_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int WINDOW = 4,
    parameter  int CNT_W  = 16,
    localparam int IDX_W  = clog2w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef COINC_MASK_EN
    input  logic [WIDTH-1:0] ch_mask,
`endif
    input  logic             clr_cnt,
    output logic             match,
    output logic             match_pulse,
    output logic [WIDTH-1:0] match_bits,
    output logic [IDX_W-1:0] match_idx,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_ovf
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_sat(CNT_W));

    logic [WIDTH-1:0] a_win;
    logic [WIDTH-1:0] b_win;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] c_q;
    logic [IDX_W-1:0] idx_nxt;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        coinc_stretch #(.WINDOW(WINDOW)) u_a (
            .clk    (clk),
            .rst    (rst),
            .enable (enable),
            .hit    (a_in[g]),
            .win    (a_win[g])
        );
        coinc_stretch #(.WINDOW(WINDOW)) u_b (
            .clk    (clk),
            .rst    (rst),
            .enable (enable),
            .hit    (b_in[g]),
            .win    (b_win[g])
        );
    end

`ifdef COINC_MASK_EN
    // Mask is registered alongside the hit windows so it lines up with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '1;
        end else begin
            mask_q <= ch_mask;
        end
    end
`else
    assign mask_q = '1;
`endif

    // Per-channel coincidence of the two open windows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q <= '0;
        end else begin
            c_q <= a_win & b_win & mask_q;
        end
    end

    // Lowest set channel; scanning down lets the lowest index win.
    always_comb begin
        idx_nxt = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (c_q[i]) begin
                idx_nxt = IDX_W'(i);
            end
        end
    end

    // Registered match outputs; pulse only on the rising edge of match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_bits  <= '0;
            match       <= 1'b0;
            match_idx   <= '0;
            match_pulse <= 1'b0;
        end else begin
            match_bits  <= c_q;
            match       <= |c_q;
            match_idx   <= idx_nxt;
            match_pulse <= (|c_q) & ~match;
        end
    end

    // Saturating event counter; clear has priority over a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
            cnt_ovf   <= 1'b0;
        end else if (clr_cnt) begin
            match_cnt <= '0;
            cnt_ovf   <= 1'b0;
        end else if (match_pulse) begin
            if (match_cnt == CNT_SAT) begin
                cnt_ovf <= 1'b1;
            end else begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_coinc_match.sv
// tb_coinc_match: vector table plus hand sequences for coinc_match.
// Expected match results go through a queue; counter checked against a model.
module tb_coinc_match;

    localparam int W   = 32;
    localparam int WIN = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          clr_cnt;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
`ifdef COINC_MASK_EN
    logic [W-1:0]  ch_mask;
`endif
    logic          match;
    logic          match_pulse;
    logic [W-1:0]  match_bits;
    logic [4:0]    match_idx;
    logic [CW-1:0] match_cnt;
    logic          cnt_ovf;

    coinc_match #(.WIDTH(W), .WINDOW(WIN), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .a_in        (a_in),
        .b_in        (b_in),
`ifdef COINC_MASK_EN
        .ch_mask     (ch_mask),
`endif
        .clr_cnt     (clr_cnt),
        .match       (match),
        .match_pulse (match_pulse),
        .match_bits  (match_bits),
        .match_idx   (match_idx),
        .match_cnt   (match_cnt),
        .cnt_ovf     (cnt_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        m;
        logic [31:0] bits;
        logic [4:0]  idx;
    } vec_t;

    typedef struct {
        logic        m;
        logic [31:0] bits;
        logic [4:0]  idx;
        logic        p;
    } exp_t;

    exp_t q[$];
    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;
    logic exp_ovf = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cnt_inc();
        if (exp_cnt == (1 << CW) - 1) exp_ovf = 1'b1;
        else exp_cnt++;
    endtask

    task automatic idle(input int n);
        a_in = '0;
        b_in = '0;
        repeat (n) tick();
    endtask

    // One-cycle hit pair; check at +2 via queue, counter at +3.
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t g;
        e.m = v.m;
        e.bits = v.bits;
        e.idx = v.idx;
        e.p = v.m;
        a_in = v.a;
        b_in = v.b;
        q.push_back(e);
        tick();
        a_in = '0;
        b_in = '0;
        tick();
        tick();
        g = q.pop_front();
        chk("vec_match", 32'(match), 32'(g.m));
        chk("vec_bits", match_bits, g.bits);
        chk("vec_idx", 32'(match_idx), 32'(g.idx));
        chk("vec_pulse", 32'(match_pulse), 32'(g.p));
        if (g.m) cnt_inc();
        tick();
        chk("vec_cnt", 32'(match_cnt), 32'(exp_cnt));
        chk("vec_pulse_once", 32'(match_pulse), 32'(0));
        idle(8);
    endtask

    // Bit 3 on one side, the other side k cycles later.
    task automatic win_pair(input bit a_first, input int k, input bit exp_m);
        int seen;
        int pulses;
        if (k == 0) begin
            a_in = 32'h8;
            b_in = 32'h8;
            tick();
        end else begin
            if (a_first) a_in = 32'h8;
            else b_in = 32'h8;
            tick();
            a_in = '0;
            b_in = '0;
            repeat (k - 1) tick();
            if (a_first) b_in = 32'h8;
            else a_in = 32'h8;
            tick();
        end
        a_in = '0;
        b_in = '0;
        seen = 0;
        pulses = 0;
        repeat (10) begin
            tick();
            seen |= int'(match);
            pulses += int'(match_pulse);
        end
        chk($sformatf("win_seen_k%0d", k), 32'(seen), 32'(exp_m));
        chk($sformatf("win_pulses_k%0d", k), 32'(pulses), 32'(exp_m));
        if (exp_m) cnt_inc();
        chk("win_cnt", 32'(match_cnt), 32'(exp_cnt));
    endtask

    initial begin
        int seen;
        int pulses;
        vecs[0] = '{32'h0000_0020, 32'h0000_0020, 1'b1, 32'h0000_0020, 5'd5};
        vecs[1] = '{32'h0000_0084, 32'h0000_0084, 1'b1, 32'h0000_0084, 5'd2};
        vecs[2] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0000, 5'd0};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 5'd31};
        vecs[4] = '{32'hFFFF_0000, 32'h0001_FFFF, 1'b1, 32'h0001_0000, 5'd16};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 5'd0};

        rst = 1'b1;
        enable = 1'b1;
        clr_cnt = 1'b0;
        a_in = '0;
        b_in = '0;
`ifdef COINC_MASK_EN
        ch_mask = '1;
`endif
        #2;
        chk("rst_match", 32'(match), 32'(0));
        chk("rst_cnt", 32'(match_cnt), 32'(0));
        tick();
        rst = 1'b0;
        idle(2);

        // Reset while a coincidence is live and windows are still open.
        a_in = $urandom | 32'h1;
        b_in = a_in;
        tick();
        a_in = '0;
        b_in = '0;
        tick();
        tick();
        chk("pre_rst_match", 32'(match), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_match", 32'(match), 32'(0));
        chk("arst_bits", match_bits, 32'(0));
        chk("arst_idx", 32'(match_idx), 32'(0));
        chk("arst_pulse", 32'(match_pulse), 32'(0));
        chk("arst_cnt", 32'(match_cnt), 32'(0));
        chk("arst_ovf", 32'(cnt_ovf), 32'(0));
        tick();
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            tick();
            seen |= int'(match);
        end
        chk("post_rst_quiet", 32'(seen), 32'(0));

        for (int i = 0; i < 6; i++) apply(vecs[i]);

        win_pair(1'b1, 3, 1'b1);
        win_pair(1'b1, 4, 1'b0);
        win_pair(1'b0, 3, 1'b1);
        win_pair(1'b0, 4, 1'b0);
        win_pair(1'b1, 0, 1'b1);

        // Disabled: hits ignored, count retained.
        enable = 1'b0;
        a_in = 32'h10;
        b_in = 32'h10;
        tick();
        seen = 0;
        a_in = '0;
        b_in = '0;
        repeat (8) begin
            tick();
            seen |= int'(match);
        end
        chk("dis_quiet", 32'(seen), 32'(0));
        chk("dis_cnt", 32'(match_cnt), 32'(exp_cnt));
        enable = 1'b1;

        // Held coincidence: single pulse.
        a_in = 32'h40;
        b_in = 32'h40;
        pulses = 0;
        seen = 1;
        repeat (12) begin
            tick();
            pulses += int'(match_pulse);
        end
        seen = int'(match);
        chk("hold_match", 32'(seen), 32'(1));
        chk("hold_pulses", 32'(pulses), 32'(1));
        cnt_inc();
        idle(8);
        chk("hold_cnt", 32'(match_cnt), 32'(exp_cnt));

        // Saturation from a cleared counter.
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        exp_cnt = 0;
        exp_ovf = 1'b0;
        chk("clr_cnt", 32'(match_cnt), 32'(0));
        chk("clr_ovf", 32'(cnt_ovf), 32'(0));
        for (int i = 0; i < 16; i++) begin
            a_in = 32'h1;
            b_in = 32'h1;
            tick();
            idle(10);
            cnt_inc();
        end
        chk("sat_cnt", 32'(match_cnt), 32'(exp_cnt));
        chk("sat_ovf", 32'(cnt_ovf), 32'(exp_ovf));

        // Clear coincident with a pulse.
        a_in = 32'h1;
        b_in = 32'h1;
        tick();
        a_in = '0;
        b_in = '0;
        tick();
        tick();
        chk("clrp_pulse", 32'(match_pulse), 32'(1));
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clrp_cnt", 32'(match_cnt), 32'(0));
        chk("clrp_ovf", 32'(cnt_ovf), 32'(0));
        idle(8);
        chk("clrp_cnt_after", 32'(match_cnt), 32'(0));

`ifdef COINC_MASK_EN
        ch_mask = ~32'h20;
        tick();
        a_in = 32'h20;
        b_in = 32'h20;
        tick();
        seen = 0;
        a_in = '0;
        b_in = '0;
        repeat (8) begin
            tick();
            seen |= int'(match);
        end
        chk("mask_blocked", 32'(seen), 32'(0));
        a_in = 32'h40;
        b_in = 32'h40;
        tick();
        a_in = '0;
        b_in = '0;
        tick();
        tick();
        chk("mask_match", 32'(match), 32'(1));
        chk("mask_idx", 32'(match_idx), 32'(6));
        idle(8);
        ch_mask = '1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
